// File: rtl/triangle_wave_monitor_if.sv
// Sample-in / measurement-out bundle of the triangle wave monitor.
// The master drives samples; the slave (the monitor) returns measurements.
interface triangle_wave_monitor_if #(
   parameter int DATA_WIDTH   = 12,
   parameter int PERIOD_WIDTH = 16
);
   logic [DATA_WIDTH-1:0]   triangle_wave;
   logic                    sample_valid;
   logic                    direction;
   logic [DATA_WIDTH-1:0]   peak_value;
   logic [DATA_WIDTH-1:0]   trough_value;
   logic                    peak_strobe;
   logic                    trough_strobe;
   logic [PERIOD_WIDTH-1:0] period;
   logic                    period_valid;
   logic                    slope_error;
   logic [7:0]              error_count;
   logic                    lock;

   modport master (
      output triangle_wave, sample_valid,
      input  direction, peak_value, trough_value, peak_strobe, trough_strobe,
             period, period_valid, slope_error, error_count, lock
   );

   modport slave (
      input  triangle_wave, sample_valid,
      output direction, peak_value, trough_value, peak_strobe, trough_strobe,
             period, period_valid, slope_error, error_count, lock
   );
endinterface

// File: rtl/triangle_wave_monitor.sv
// Tracks a fixed-slope triangle wave: peaks, troughs, trough-to-trough period,
// slope violations and a lock indication after enough clean periods.
module triangle_wave_monitor #(
   parameter int DATA_WIDTH   = 12,
   parameter int STEP         = 1,
   parameter int PERIOD_WIDTH = 16,
   parameter int LOCK_COUNT   = 2
) (
   input  logic ref_clk,
   input  logic rstn,
   triangle_wave_monitor_if.slave mon
);
   localparam int CW = $clog2(LOCK_COUNT + 1);
   localparam logic signed [DATA_WIDTH:0] STEP_P = (DATA_WIDTH+1)'(STEP);
   localparam logic signed [DATA_WIDTH:0] STEP_N = -STEP_P;

   typedef enum logic [1:0] {S_FIRST, S_SECOND, S_RISING, S_FALLING} state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   prev_q, prev_d;
   logic [PERIOD_WIDTH-1:0] cnt_q, cnt_d;
   logic [PERIOD_WIDTH-1:0] period_q, period_d;
   logic [DATA_WIDTH-1:0]   peak_q, peak_d, trough_q, trough_d;
   logic [7:0]              errc_q, errc_d;
   logic [CW-1:0]           clean_q, clean_d;
   logic                    seen_q, seen_d;
   logic                    lock_q, lock_d;
   logic                    dir_q, dir_d;
   logic                    pk_stb_q, pk_stb_d, tr_stb_q, tr_stb_d;
   logic                    pv_q, pv_d, err_q, err_d;
   logic                    trough_ev;
   logic signed [DATA_WIDTH:0] diff;

   // Unsigned operands zero-extended so a wrap such as 4095->0 is a large negative step
   assign diff = $signed({1'b0, mon.triangle_wave}) - $signed({1'b0, prev_q});

   always_comb begin
      state_d   = state_q;
      prev_d    = prev_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      peak_d    = peak_q;
      trough_d  = trough_q;
      errc_d    = errc_q;
      clean_d   = clean_q;
      seen_d    = seen_q;
      lock_d    = lock_q;
      pk_stb_d  = 1'b0;
      tr_stb_d  = 1'b0;
      pv_d      = 1'b0;
      err_d     = 1'b0;
      trough_ev = 1'b0;
      if (mon.sample_valid) begin
         prev_d = mon.triangle_wave;
         cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + PERIOD_WIDTH'(1);
         case (state_q)
            S_FIRST:  state_d = S_SECOND;
            S_SECOND: begin
               if (diff == STEP_P)      state_d = S_RISING;
               else if (diff == STEP_N) state_d = S_FALLING;
               else                     err_d   = 1'b1;
            end
            S_RISING: begin
               if (diff == STEP_N) begin
                  state_d  = S_FALLING;
                  peak_d   = prev_q;
                  pk_stb_d = 1'b1;
               end else if (diff != STEP_P) begin
                  err_d = 1'b1;
               end
            end
            default: begin
               if (diff == STEP_P) begin
                  state_d   = S_RISING;
                  trough_d  = prev_q;
                  tr_stb_d  = 1'b1;
                  trough_ev = 1'b1;
               end else if (diff != STEP_N) begin
                  err_d = 1'b1;
               end
            end
         endcase
         if (trough_ev) begin
            period_d = cnt_q;
            cnt_d    = PERIOD_WIDTH'(1);
            if (seen_q) begin
               pv_d = 1'b1;
               if (clean_q >= CW'(LOCK_COUNT - 1)) lock_d = 1'b1;
               if (clean_q != CW'(LOCK_COUNT))     clean_d = clean_q + CW'(1);
            end else begin
               seen_d = 1'b1;
            end
         end
         if (err_d) begin
            errc_d  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;
            state_d = S_SECOND;
            cnt_d   = '0;
            seen_d  = 1'b0;
            lock_d  = 1'b0;
            clean_d = '0;
         end
      end
      dir_d = (state_d == S_RISING);
   end

   always_ff @(posedge ref_clk) begin
      if (!rstn) begin
         state_q  <= S_FIRST;
         prev_q   <= '0;
         cnt_q    <= '0;
         period_q <= '0;
         peak_q   <= '0;
         trough_q <= '0;
         errc_q   <= '0;
         clean_q  <= '0;
         seen_q   <= 1'b0;
         lock_q   <= 1'b0;
         dir_q    <= 1'b0;
         pk_stb_q <= 1'b0;
         tr_stb_q <= 1'b0;
         pv_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         peak_q   <= peak_d;
         trough_q <= trough_d;
         errc_q   <= errc_d;
         clean_q  <= clean_d;
         seen_q   <= seen_d;
         lock_q   <= lock_d;
         dir_q    <= dir_d;
         pk_stb_q <= pk_stb_d;
         tr_stb_q <= tr_stb_d;
         pv_q     <= pv_d;
         err_q    <= err_d;
      end
   end

   assign mon.direction     = dir_q;
   assign mon.peak_value    = peak_q;
   assign mon.trough_value  = trough_q;
   assign mon.peak_strobe   = pk_stb_q;
   assign mon.trough_strobe = tr_stb_q;
   assign mon.period        = period_q;
   assign mon.period_valid  = pv_q;
   assign mon.slope_error   = err_q;
   assign mon.error_count   = errc_q;
   assign mon.lock          = lock_q;
endmodule

// File: tb/tb_triangle_wave_monitor.sv
// Randomised bench for triangle_wave_monitor against a behavioural model; a second
// instance with a 4-bit period counter exercises period saturation on the same stream.
module tb_triangle_wave_monitor;
   localparam int DW = 12;
   localparam int STEP = 1;
   localparam int LOCK = 2;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic valid = 1'b0;
   logic [DW-1:0] tw = '0;
   int checks = 0;
   int errors = 0;
   int cur = 0;
   int gap = 0;

   always #5 clk = ~clk;

   triangle_wave_monitor_if #(.DATA_WIDTH(DW), .PERIOD_WIDTH(16)) ifa ();
   triangle_wave_monitor_if #(.DATA_WIDTH(DW), .PERIOD_WIDTH(4))  ifb ();
   assign ifa.triangle_wave = tw;
   assign ifa.sample_valid  = valid;
   assign ifb.triangle_wave = tw;
   assign ifb.sample_valid  = valid;

   triangle_wave_monitor #(.DATA_WIDTH(DW), .STEP(STEP), .PERIOD_WIDTH(16), .LOCK_COUNT(LOCK))
      dut_a (.ref_clk(clk), .rstn(rstn), .mon(ifa));
   triangle_wave_monitor #(.DATA_WIDTH(DW), .STEP(STEP), .PERIOD_WIDTH(4), .LOCK_COUNT(LOCK))
      dut_b (.ref_clk(clk), .rstn(rstn), .mon(ifb));

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: slope direction as +1/-1/0, periods as plain saturating integers.
   int  m_prev, m_dir, m_cnt_a, m_cnt_b, m_clean, m_errc;
   bit  m_has_prev, m_seen;
   int  e_peak, e_trough, e_per_a, e_per_b, e_errc;
   bit  e_dir, e_pk, e_tr, e_pv, e_err, e_lock;

   task automatic model_step();
      int d, old_a, old_b;
      bit err, trough;
      e_pk = 0; e_tr = 0; e_pv = 0; e_err = 0;
      if (!rstn) begin
         m_prev = 0; m_dir = 0; m_cnt_a = 0; m_cnt_b = 0; m_clean = 0; m_errc = 0;
         m_has_prev = 0; m_seen = 0;
         e_peak = 0; e_trough = 0; e_per_a = 0; e_per_b = 0; e_lock = 0;
      end else if (valid) begin
         d = int'(tw) - m_prev;
         err = 0; trough = 0;
         old_a = m_cnt_a; old_b = m_cnt_b;
         m_cnt_a = (m_cnt_a + 1 > 65535) ? 65535 : m_cnt_a + 1;
         m_cnt_b = (m_cnt_b + 1 > 15) ? 15 : m_cnt_b + 1;
         if (!m_has_prev) m_has_prev = 1;
         else if (m_dir == 0) begin
            if (d == STEP) m_dir = 1;
            else if (d == -STEP) m_dir = -1;
            else err = 1;
         end else if (d == m_dir * STEP) begin
         end else if (d == -m_dir * STEP) begin
            if (m_dir == 1) begin e_peak = m_prev; e_pk = 1; end
            else begin e_trough = m_prev; e_tr = 1; trough = 1; end
            m_dir = -m_dir;
         end else err = 1;
         if (trough) begin
            e_per_a = old_a; e_per_b = old_b; m_cnt_a = 1; m_cnt_b = 1;
            if (m_seen) begin
               e_pv = 1; m_clean++;
               if (m_clean >= LOCK) e_lock = 1;
            end else m_seen = 1;
         end
         if (err) begin
            e_err = 1; m_errc = (m_errc == 255) ? 255 : m_errc + 1;
            m_dir = 0; m_cnt_a = 0; m_cnt_b = 0; m_seen = 0; e_lock = 0; m_clean = 0;
         end
         m_prev = int'(tw);
      end
      e_dir = (m_dir == 1);
      e_errc = m_errc;
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("direction", int'(ifa.direction), int'(e_dir));
      check("peak_value", int'(ifa.peak_value), e_peak);
      check("trough_value", int'(ifa.trough_value), e_trough);
      check("peak_strobe", int'(ifa.peak_strobe), int'(e_pk));
      check("trough_strobe", int'(ifa.trough_strobe), int'(e_tr));
      check("period", int'(ifa.period), e_per_a);
      check("period_valid", int'(ifa.period_valid), int'(e_pv));
      check("slope_error", int'(ifa.slope_error), int'(e_err));
      check("error_count", int'(ifa.error_count), e_errc);
      check("lock", int'(ifa.lock), int'(e_lock));
      check("period_b", int'(ifb.period), e_per_b);
      check("period_valid_b", int'(ifb.period_valid), int'(e_pv));
   end

   task automatic send(input int s);
      int n;
      n = (gap == 1) ? 1 : (gap == 2) ? $urandom_range(0, 2) : 0;
      repeat (n) begin
         @(negedge clk);
         valid = 1'b0;
         tw = DW'($urandom);
      end
      @(negedge clk);
      valid = 1'b1;
      tw = DW'(s);
   endtask

   task automatic rise_to(input int to);
      while (cur < to) begin cur++; send(cur); end
   endtask

   task automatic fall_to(input int to);
      while (cur > to) begin cur--; send(cur); end
   endtask

   task automatic idle();
      @(negedge clk);
      valid = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_lock", int'(ifa.lock), 0);
      check("rst_period", int'(ifa.period), 0);
      check("rst_errc", int'(ifa.error_count), 0);
      rstn = 1'b1;

      // Clean 0..7..0 ramp
      cur = 0; send(0);
      repeat (4) begin rise_to(7); fall_to(0); end
      idle();
      check("lit_peak", int'(ifa.peak_value), 7);
      check("lit_trough", int'(ifa.trough_value), 0);
      check("lit_period", int'(ifa.period), 14);
      check("lit_lock", int'(ifa.lock), 1);

      // Jump 3->6 while locked, then relock
      rise_to(3); cur = 6; send(6);
      idle();
      check("lit_errc_jump", int'(ifa.error_count), 1);
      check("lit_unlock", int'(ifa.lock), 0);
      rise_to(7); fall_to(0);
      repeat (3) begin rise_to(7); fall_to(0); end
      idle();
      check("lit_relock", int'(ifa.lock), 1);

      // Valid toggling every cycle
      gap = 1;
      repeat (3) begin rise_to(7); fall_to(0); end
      gap = 0;
      idle();
      check("lit_gap_period", int'(ifa.period), 14);
      check("lit_gap_peak", int'(ifa.peak_value), 7);

      // Wrap and repeated sample: 0->4095, 4095->0, 0->5, 5->5 are all illegal
      send(4095); send(0); send(5); send(5); cur = 5;
      idle();
      check("lit_errc_wrap", int'(ifa.error_count), 5);

      // Period 20 ramp: 4-bit counter saturates at 15
      fall_to(0);
      repeat (3) begin rise_to(10); fall_to(0); end
      idle();
      check("lit_period20", int'(ifa.period), 20);
      check("lit_period_sat", int'(ifb.period), 15);

      // Reset mid-ramp then relock
      rise_to(4);
      @(negedge clk); rstn = 1'b0; valid = 1'b1; tw = DW'(5);
      @(negedge clk);
      check("lit_rst_errc", int'(ifa.error_count), 0);
      check("lit_rst_peak", int'(ifa.peak_value), 0);
      check("lit_rst_dir", int'(ifa.direction), 0);
      rstn = 1'b1;
      send(cur); rise_to(7);
      repeat (3) begin fall_to(0); rise_to(7); end
      idle();
      check("lit_rst_relock", int'(ifa.lock), 1);

      // Noise burst drives the error counter into saturation
      repeat (280) send(int'($urandom_range(0, 4095)));
      idle();
      check("lit_errc_sat", int'(ifa.error_count), 255);
      pulse_reset();

      // Random segments
      cur = $urandom_range(0, 4000); send(cur);
      repeat (60) begin
         int k;
         k = $urandom_range(0, 9);
         gap = ($urandom_range(0, 3) == 0) ? 2 : 0;
         if (k <= 5) begin
            rise_to((cur + $urandom_range(1, 12) > 4095) ? 4095 : cur + $urandom_range(1, 12));
            fall_to((cur < 12) ? 0 : cur - $urandom_range(1, 12));
         end else if (k == 6) begin
            cur = $urandom_range(0, 4095); send(cur);
         end else if (k == 7) begin
            send(cur);
         end else if (k == 8) begin
            pulse_reset(); send(cur);
         end else begin
            repeat (5) begin
               if (cur < 4095) cur++;
               send(cur);
            end
         end
      end
      gap = 0;
      idle(); idle();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule

// File: doc/triangle_wave_monitor.md
TRIANGLE_WAVE_MONITOR -- requirements
Module: triangle_wave_monitor

Interface
REQ-001 Parameter DATA_WIDTH, default 12: sample width.
REQ-002 Parameter STEP, default 1: expected absolute per-sample slope.
REQ-003 Parameter PERIOD_WIDTH, default 16: width of period counter and output.
REQ-004 Parameter LOCK_COUNT, default 2: consecutive clean periods required for lock.
REQ-005 ref_clk  input  1  single clock; all logic on rising edge.
REQ-006 rstn  input  1  synchronous reset, active-low.
REQ-007 triangle_wave  input  DATA_WIDTH  unsigned sample under test.
REQ-008 sample_valid  input  1  sample qualifier; sample ignored when low.
REQ-009 direction  output  1  1 = rising, 0 = falling or unknown.
REQ-010 peak_value  output  DATA_WIDTH  last detected peak sample.
REQ-011 trough_value  output  DATA_WIDTH  last detected trough sample.
REQ-012 peak_strobe / trough_strobe  output  1 each  one-cycle pulses on detection.
REQ-013 period  output  PERIOD_WIDTH  samples between last two troughs.
REQ-014 period_valid  output  1  one-cycle pulse when period updates.
REQ-015 slope_error  output  1  one-cycle pulse on illegal step.
REQ-016 error_count  output  8  saturating count of slope errors.
REQ-017 lock  output  1  waveform tracked cleanly.

Function
REQ-018 States: FIRST, SECOND, RISING, FALLING; only accepted samples (sample_valid=1) advance state or counters.
REQ-019 All outputs registered; response to a sample visible the cycle after it is presented.
REQ-020 prev holds the last accepted sample; diff = triangle_wave - prev, computed signed in DATA_WIDTH+1 bits, no wrap (4095->0 is diff -4095, an error).
REQ-021 FIRST: store sample into prev -> SECOND; no checks.
REQ-022 SECOND: diff=+STEP -> RISING, direction=1; diff=-STEP -> FALLING, direction=0; else slope_error, stay SECOND.
REQ-023 RISING: diff=+STEP stay; diff=-STEP -> FALLING, peak_value<=prev, peak_strobe=1; else error.
REQ-024 FALLING: diff=-STEP stay; diff=+STEP -> RISING, trough_value<=prev, trough_strobe=1, trough event; else error.
REQ-025 diff=0 is an error in every checking state.
REQ-026 Period counter cnt: on trough event period<=cnt, cnt<=1; otherwise cnt<=cnt+1 per accepted sample, saturating at all-ones.
REQ-027 period_valid pulses only on trough events after the first trough since reset or last error.
REQ-028 Error: slope_error=1, error_count+1 (saturates at 255), prev<=current sample, state->SECOND, cnt cleared, first-trough flag cleared, lock<=0, clean-period count cleared.
REQ-029 lock<=1 in the cycle of the LOCK_COUNT-th consecutive period_valid with no intervening error; holds until next error or reset.
REQ-030 sample_valid low: all state, prev and counters hold; strobes low.
REQ-031 Strobes, period_valid and slope_error never assert for more than one cycle per accepted sample.

Reset
REQ-032 rstn sampled low at a ref_clk edge: state FIRST, prev 0, cnt 0, all outputs 0 (period, peak_value, trough_value, error_count, lock included), next cycle.
REQ-033 Reset mid-waveform discards all history; first post-reset sample treated per REQ-021.

Verification
REQ-034 Reset, then STEP=1 ramp 0..7..0 repeated, valid every cycle -> peak_value=7, trough_value=0, period=14 on each period_valid after the first trough, lock=1 on second period_valid.
REQ-035 Locked stream, inject jump 3->6 -> slope_error one cycle, error_count=1, lock=0, period_valid withheld until two troughs pass, lock regained after two more clean periods.
REQ-036 sample_valid toggled 1/0 every cycle on same ramp -> identical period=14, peak/trough values as REQ-034.
REQ-037 Sample sequence 4095 then 0 -> slope_error; repeated sample 5,5 -> slope_error.
REQ-038 Ramp with cnt forced past 2^PERIOD_WIDTH-1 (PERIOD_WIDTH=4, period 20) -> period=15 saturated.
REQ-039 rstn low for one cycle mid-ramp -> all outputs 0 next cycle; resumed ramp relocks per REQ-034.
